// File: rtl/particle_slot_manager_pkg.sv
// particle_slot_manager_pkg
// Shared constants for the particle slot manager and the draw engine it
// talks to: FSM state encoding, request op codes, spawn LFSR seed/taps and
// the default screen extents.
package particle_slot_manager_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic OP_ERASE = 1'b0;
  localparam logic OP_DRAW  = 1'b1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

endpackage

// File: rtl/particle_slot_manager_if.sv
// particle_slot_manager_if
// Valid/ack request channel from the slot manager to the VGA draw engine.
//   req_valid  request pending (held until acked)
//   req_op     1 = draw (spawn), 0 = erase (despawn)
//   req_slot   slot index
//   req_x/y    particle coordinates
//   req_ack    draw engine accepted/completed the request
// master = slot manager, slave = draw engine.
interface particle_slot_manager_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic           req_valid;
  logic           req_op;
  logic [2:0]     req_slot;
  logic [X_W-1:0] req_x;
  logic [Y_W-1:0] req_y;
  logic           req_ack;

  modport master (
    output req_valid, req_op, req_slot, req_x, req_y,
    input  req_ack
  );

  modport slave (
    input  req_valid, req_op, req_slot, req_x, req_y,
    output req_ack
  );
endinterface

// File: rtl/particle_slot_manager_spawn_lfsr.sv
// spawn_lfsr
// Free-running 16-bit Fibonacci LFSR (advances every cycle) plus the fold of
// its bits into on-screen spawn coordinates:
//   x = lfsr[7:0]  less (X_MAX+1) when above X_MAX
//   y = lfsr[14:8] less (Y_MAX+1) when above Y_MAX
// Ports: clk, rst (sync, active high, reloads seed), x, y (combinational
// from the current LFSR state).
module spawn_lfsr
  import particle_slot_manager_pkg::*;
#(
  parameter int X_W   = 8,
  parameter int Y_W   = 7,
  parameter int X_MAX = SCREEN_X_MAX,
  parameter int Y_MAX = SCREEN_Y_MAX
) (
  input  logic           clk,
  input  logic           rst,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y
);

  logic [15:0] lfsr;
  logic [8:0]  raw_x;
  logic [7:0]  raw_y;

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  // One subtraction suffices: raw range is below twice the screen extent.
  always_comb begin
    raw_x = {1'b0, lfsr[7:0]};
    raw_y = {1'b0, lfsr[14:8]};
    if (raw_x > 9'(X_MAX)) raw_x = raw_x - 9'(X_MAX + 1);
    if (raw_y > 8'(Y_MAX)) raw_y = raw_y - 8'(Y_MAX + 1);
    x = X_W'(raw_x);
    y = Y_W'(raw_y);
  end

endmodule

// File: rtl/particle_slot_manager.sv
// particle_slot_manager
// Brings the set of active particle slots into agreement with the clamped
// mole count, one slot per draw-engine request (spawn = draw, despawn =
// erase). Owns the active mask and per-slot spawn coordinates.
// Ports:
//   clk, Reset    clock, synchronous active-high reset
//   numMoles      target particle count (0 -> 1, >MAX_PARTICLES -> clamp)
//   bus           request channel to the draw engine (master side)
//   activeMask    bit i = slot i active
//   activeCount   popcount of activeMask
//   busy          request in flight
// Build option: RANDOM_SPAWN_EN selects LFSR spawn positions; otherwise
// slot s spawns at x = 20*(s+1), y = (Y_MAX+1)/2.
module particle_slot_manager
  import particle_slot_manager_pkg::*;
#(
  parameter int MAX_PARTICLES = 5,
  parameter int X_W           = 8,
  parameter int Y_W           = 7,
  parameter int X_MAX         = SCREEN_X_MAX,
  parameter int Y_MAX         = SCREEN_Y_MAX
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic [2:0]               numMoles,
  particle_slot_manager_if.master  bus,
  output logic [MAX_PARTICLES-1:0] activeMask,
  output logic [2:0]               activeCount,
  output logic                     busy
);

  localparam logic [2:0] MAXP = 3'(MAX_PARTICLES);

  state_t state, state_nxt;

  logic [2:0]                         target;
  logic [2:0]                         free_slot;
  logic [2:0]                         high_slot;
  logic                               spawn;
  logic                               despawn;
  logic [X_W-1:0]                     spawn_x;
  logic [Y_W-1:0]                     spawn_y;
  logic [MAX_PARTICLES-1:0][X_W-1:0]  pos_x;
  logic [MAX_PARTICLES-1:0][Y_W-1:0]  pos_y;

  // ---------------------------------------------------------------------
  // Spawn coordinate source
  // ---------------------------------------------------------------------
`ifdef RANDOM_SPAWN_EN
  spawn_lfsr #(
    .X_W   (X_W),
    .Y_W   (Y_W),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_spawn_lfsr (
    .clk (clk),
    .rst (Reset),
    .x   (spawn_x),
    .y   (spawn_y)
  );
`else
  // Fixed column per slot; the clamp only matters on narrow screens.
  always_comb begin
    int fx;
    fx = 20 * (int'(free_slot) + 1);
    if (fx > X_MAX) fx = X_MAX;
    spawn_x = X_W'(fx);
    spawn_y = Y_W'((Y_MAX + 1) / 2);
  end
`endif

  // ---------------------------------------------------------------------
  // Target clamp, population count, slot selection
  // ---------------------------------------------------------------------
  always_comb begin
    if (numMoles == 3'd0)     target = 3'd1;
    else if (numMoles > MAXP) target = MAXP;
    else                      target = numMoles;
  end

  always_comb begin
    activeCount = '0;
    for (int i = 0; i < MAX_PARTICLES; i++)
      activeCount = activeCount + 3'(activeMask[i]);
  end

  // Lowest free slot for spawns, highest active slot for despawns.
  always_comb begin
    free_slot = '0;
    high_slot = '0;
    for (int i = MAX_PARTICLES - 1; i >= 0; i--)
      if (!activeMask[i]) free_slot = 3'(i);
    for (int i = 0; i < MAX_PARTICLES; i++)
      if (activeMask[i]) high_slot = 3'(i);
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    spawn     = 1'b0;
    despawn   = 1'b0;
    case (state)
      IDLE: begin
        spawn   = (activeCount < target);
        despawn = (activeCount > target);
        if (spawn || despawn) state_nxt = REQ;
      end
      REQ: begin
        // numMoles is not consulted here: an in-flight request always
        // completes and the next IDLE cycle re-evaluates.
        if (bus.req_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_valid = (state == REQ);
  assign busy          = (state != IDLE);

  // ---------------------------------------------------------------------
  // Request fields, position registers, active mask
  // ---------------------------------------------------------------------
  // Request fields are only loaded on the IDLE->REQ decision, so they stay
  // frozen for as long as the draw engine takes to ack.
  always_ff @(posedge clk) begin
    if (Reset) begin
      bus.req_op   <= OP_ERASE;
      bus.req_slot <= '0;
      bus.req_x    <= '0;
      bus.req_y    <= '0;
      pos_x        <= '0;
      pos_y        <= '0;
      activeMask   <= '0;
    end else begin
      if (spawn) begin
        bus.req_op       <= OP_DRAW;
        bus.req_slot     <= free_slot;
        bus.req_x        <= spawn_x;
        bus.req_y        <= spawn_y;
        pos_x[free_slot] <= spawn_x;
        pos_y[free_slot] <= spawn_y;
      end else if (despawn) begin
        // Erase must hit the pixels that were drawn, so reuse the stored
        // coordinates rather than the current spawn source.
        bus.req_op   <= OP_ERASE;
        bus.req_slot <= high_slot;
        bus.req_x    <= pos_x[high_slot];
        bus.req_y    <= pos_y[high_slot];
      end
      if (state == REQ && bus.req_ack)
        activeMask[bus.req_slot] <= (bus.req_op == OP_DRAW);
    end
  end

endmodule

// File: tb/tb_particle_slot_manager.sv
// tb_particle_slot_manager
// Directed bench for particle_slot_manager in the default build (fixed
// spawn positions: x = 20*(slot+1), y = 60). Acts as the draw engine.
module tb_particle_slot_manager;

  logic       clk = 1'b0;
  logic       Reset;
  logic [2:0] numMoles;
  logic [4:0] activeMask;
  logic [2:0] activeCount;
  logic       busy;

  int checks = 0;
  int errors = 0;

  particle_slot_manager_if #(.X_W(8), .Y_W(7)) bus();

  particle_slot_manager dut (
    .clk         (clk),
    .Reset       (Reset),
    .numMoles    (numMoles),
    .bus         (bus),
    .activeMask  (activeMask),
    .activeCount (activeCount),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for a request (bounded), check its latency and fields, hold it for
  // 'delay' cycles checking that nothing moves, then ack and check the mask.
  task automatic do_req(input string tag, input logic op, input int slot,
                        input int x, input int y, input int delay,
                        input logic [4:0] m_before);
    int n;
    logic [4:0] m_after;
    n = 0;
    while (!bus.req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 1);
    chk({tag, "_op"},   bus.req_op, op);
    chk({tag, "_slot"}, bus.req_slot, slot);
    chk({tag, "_x"},    bus.req_x, x);
    chk({tag, "_y"},    bus.req_y, y);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.req_valid, 1);
      chk({tag, "_hold_fields"}, {bus.req_op, bus.req_slot, bus.req_x, bus.req_y},
          {op, 3'(slot), 8'(x), 7'(y)});
      chk({tag, "_hold_mask"}, activeMask, m_before);
    end
    m_after = m_before;
    m_after[slot] = op;
    bus.req_ack = 1'b1;
    @(negedge clk);
    bus.req_ack = 1'b0;
    chk({tag, "_valid_low"}, bus.req_valid, 0);
    chk({tag, "_mask"}, activeMask, m_after);
  endtask

  initial begin
    Reset       = 1'b1;
    numMoles    = 3'd1;
    bus.req_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.req_valid, 0);
    chk("rst_mask",  activeMask, 0);
    chk("rst_count", activeCount, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fields", {bus.req_op, bus.req_slot, bus.req_x, bus.req_y}, 0);
    Reset = 1'b0;

    // First spawn after reset, ack one cycle after valid.
    do_req("spawn0", 1'b1, 0, 20, 60, 0, 5'b00000);
    chk("s0_count", activeCount, 1);
    chk("s0_busy",  busy, 0);

    // 1 -> 5: slots 1..4 in order.
    numMoles = 3'd5;
    do_req("spawn1", 1'b1, 1, 40, 60, 0, 5'b00001);
    do_req("spawn2", 1'b1, 2, 60, 60, 0, 5'b00011);
    do_req("spawn3", 1'b1, 3, 80, 60, 0, 5'b00111);
    do_req("spawn4", 1'b1, 4, 100, 60, 0, 5'b01111);
    chk("full_count", activeCount, 5);
    @(negedge clk);
    chk("full_idle", bus.req_valid, 0);

    // 5 -> 3: erase 4 then 3 with stored coordinates.
    numMoles = 3'd3;
    do_req("erase4", 1'b0, 4, 100, 60, 0, 5'b11111);
    do_req("erase3", 1'b0, 3, 80, 60, 0, 5'b01111);
    chk("e_count", activeCount, 3);

    // Ack delayed 12 cycles.
    numMoles = 3'd4;
    do_req("slow3", 1'b1, 3, 80, 60, 12, 5'b00111);
    chk("slow_count", activeCount, 4);

    // numMoles = 0 behaves as 1.
    numMoles = 3'd0;
    do_req("z_e3", 1'b0, 3, 80, 60, 0, 5'b01111);
    do_req("z_e2", 1'b0, 2, 60, 60, 0, 5'b00111);
    do_req("z_e1", 1'b0, 1, 40, 60, 0, 5'b00011);
    @(negedge clk);
    chk("zero_idle", busy, 0);
    chk("zero_count", activeCount, 1);

    // numMoles = 7 behaves as 5.
    numMoles = 3'd7;
    do_req("c_s1", 1'b1, 1, 40, 60, 0, 5'b00001);
    do_req("c_s2", 1'b1, 2, 60, 60, 0, 5'b00011);
    do_req("c_s3", 1'b1, 3, 80, 60, 0, 5'b00111);
    do_req("c_s4", 1'b1, 4, 100, 60, 0, 5'b01111);
    @(negedge clk);
    chk("clamp_idle", busy, 0);
    chk("clamp_count", activeCount, 5);

    // Down to 2.
    numMoles = 3'd2;
    do_req("d_e4", 1'b0, 4, 100, 60, 0, 5'b11111);
    do_req("d_e3", 1'b0, 3, 80, 60, 0, 5'b01111);
    do_req("d_e2", 1'b0, 2, 60, 60, 0, 5'b00111);
    chk("two_count", activeCount, 2);

    // 2 -> 4 starts a draw; 4 -> 2 during the request must not abort it.
    numMoles = 3'd4;
    @(negedge clk);
    chk("mid_valid", bus.req_valid, 1);
    chk("mid_slot",  bus.req_slot, 2);
    numMoles = 3'd2;
    @(negedge clk);
    chk("mid_held", bus.req_valid, 1);
    bus.req_ack = 1'b1;
    @(negedge clk);
    bus.req_ack = 1'b0;
    chk("mid_mask", activeMask, 5'b00111);
    do_req("mid_e2", 1'b0, 2, 60, 60, 0, 5'b00111);
    repeat (3) @(negedge clk);
    chk("mid_final_count", activeCount, 2);
    chk("mid_final_busy", busy, 0);

    // Reset while a request is pending.
    numMoles = 3'd3;
    @(negedge clk);
    chk("rr_valid", bus.req_valid, 1);
    Reset = 1'b1;
    numMoles = 3'd1;
    @(negedge clk);
    chk("rr_valid_low", bus.req_valid, 0);
    chk("rr_mask", activeMask, 0);
    Reset = 1'b0;
    do_req("rr_spawn0", 1'b1, 0, 20, 60, 0, 5'b00000);

    // Ack with no request pending is ignored.
    bus.req_ack = 1'b1;
    @(negedge clk);
    bus.req_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_mask", activeMask, 5'b00001);
    chk("stray_ack_valid", bus.req_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/particle_slot_manager.md
# particle_slot_manager

Consumes the mole count from the mole counter datapath and brings the set of on-screen particles into agreement with it. It does this one particle at a time, spawning or despawning through a valid/ack request handshake to the VGA draw engine. It owns the per-slot active mask and spawn coordinates that the motion logic reads.

## Interface
- `MAX_PARTICLES`, default 5: number of particle slots; also the clamp for target count.
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `X_MAX`, default 159: largest legal x.
- `Y_MAX`, default 119: largest legal y.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `numMoles`  in  3  target particle count from the mole counter.
- `req_valid`  out  1  draw-engine request pending.
- `req_op`  out  1  1 = draw (spawn), 0 = erase (despawn).
- `req_slot`  out  3  slot index of the request.
- `req_x`  out  X_W  particle x for the request.
- `req_y`  out  Y_W  particle y for the request.
- `req_ack`  in  1  draw engine accepted/completed the request.
- `activeMask`  out  MAX_PARTICLES  bit i = slot i active.
- `activeCount`  out  3  population count of `activeMask`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, REQ.
- Target clamping: T = 1 if `numMoles` = 0; T = MAX_PARTICLES if `numMoles` > MAX_PARTICLES; otherwise T = `numMoles`.
- IDLE transitions:
  - `activeCount` < T: select the lowest-index free slot, latch its spawn position into the slot's position register, set `req_op`=1, go to REQ.
  - `activeCount` > T: select the highest-index active slot, present its stored position, set `req_op`=0, go to REQ.
  - Equal: stay in IDLE.
- REQ:
  - `req_valid`=1.
  - `req_op`, `req_slot`, `req_x` and `req_y` are held constant until acknowledged.
  - On `req_valid` & `req_ack`, a draw sets the slot's mask bit; an erase clears it and `activeCount` adjusts by 1. Then return to IDLE.
- Only one outstanding request; each request moves the count by exactly 1.
- `numMoles` changes during REQ are ignored until IDLE re-evaluates; no request is aborted.
- Spawn position (random):
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) advances every cycle, including in IDLE.
  - x = lfsr[7:0], minus (X_MAX+1) if > X_MAX.
  - y = lfsr[14:8], minus (Y_MAX+1) if > Y_MAX.
- Despawn always reuses the slot's stored coordinates, never the LFSR.

## Timing
- Reset values:
  - state IDLE, `req_valid`=0, `req_op`=0, `req_slot`=0, `req_x`=0, `req_y`=0.
  - `activeMask`=0, `activeCount`=0, `busy`=0, LFSR = seed, all position registers = 0.
- Reset asserted mid-request: `req_valid` drops at the next edge and the mask clears; the draw engine must tolerate the abandoned request.
- Mismatch sampled at edge t ⇒ `req_valid` high from t+1.
- Ack sampled at edge t+k ⇒ mask/count update and `req_valid` low at that edge.
- Next request earliest `req_valid` is at t+k+2.
- `req_ack` while `req_valid`=0 is ignored.
- After reset, `activeCount`=0 < 1, so the first spawn (slot 0) is issued unconditionally.
- Throughput: one slot change per (2 + ack latency) cycles.

## Configuration
- `RANDOM_SPAWN_EN` defined: LFSR spawn positions as above.
- `RANDOM_SPAWN_EN` undefined:
  - LFSR removed.
  - Spawn x = 20·(slot+1), y = (Y_MAX+1)/2 (60 at defaults).
  - All other behaviour identical.

## Structure
- Shared package holds:
  - state encoding constants (IDLE, REQ);
  - op constants OP_ERASE=0, OP_DRAW=1;
  - LFSR seed and tap constants;
  - default X_MAX/Y_MAX screen constants shared with the draw engine.
- One sub-module: `spawn_lfsr`, which contains the LFSR plus the coordinate fold into range. Instantiated only under `RANDOM_SPAWN_EN`.

## Test plan
- Reset, `numMoles`=1, ack 1 cycle after valid → one draw on slot 0; `activeMask`=00001, `activeCount`=1, `busy`=0.
- `numMoles` 1→5 → four draws on slots 1,2,3,4 in order; final `activeMask`=11111.
- `numMoles` 5→3 → erase slot 4 then slot 3, each with x/y equal to that slot's spawn values; final mask 00111.
- Ack delayed 12 cycles → `req_valid` high and all req fields constant for 12 cycles; single mask change on the ack edge.
- `numMoles`=0 and `numMoles`=7 → treated as 1 and 5; `numMoles` 2→4 mid-request then 4→2 before ack → the in-flight draw completes, then one erase, count ends at 2.
- `Reset` pulsed during REQ → `req_valid`=0 and mask 0 next cycle, then spawn of slot 0 re-issued. With `RANDOM_SPAWN_EN` undefined, all x ∈ {20,40,60,80,100} and y=60.
